// File: rtl/direction_encoder_pkg.sv
// Shared direction codes and FSM state encoding for the direction encoder.
package direction_encoder_pkg;

  localparam logic [2:0] DIR_NONE      = 3'd0;
  localparam logic [2:0] DIR_FORWARD   = 3'd1;
  localparam logic [2:0] DIR_BACKWARD  = 3'd2;
  localparam logic [2:0] DIR_LFORWARD  = 3'd3;
  localparam logic [2:0] DIR_LBACKWARD = 3'd4;
  localparam logic [2:0] DIR_RFORWARD  = 3'd5;
  localparam logic [2:0] DIR_RBACKWARD = 3'd6;
  localparam logic [2:0] DIR_INVALID   = 3'b111;

  // Two's-complement 2-bit axis values.
  localparam logic [1:0] VEC_NEG  = 2'b11;
  localparam logic [1:0] VEC_ZERO = 2'b00;
  localparam logic [1:0] VEC_POS  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/direction_encoder_dir_code_to_vec.sv
// Combinational map from a direction code to its signed (x, y) pair.
module dir_code_to_vec
  import direction_encoder_pkg::*;
(
  input  logic [2:0] code,
  output logic [1:0] x,
  output logic [1:0] y,
  output logic       known
);

  always_comb begin
    x     = VEC_ZERO;
    y     = VEC_ZERO;
    known = 1'b1;
    case (code)
      DIR_NONE:      ;
      DIR_FORWARD:   y = VEC_POS;
      DIR_BACKWARD:  y = VEC_NEG;
      DIR_LFORWARD:  begin x = VEC_NEG; y = VEC_POS; end
      DIR_LBACKWARD: begin x = VEC_NEG; y = VEC_NEG; end
      DIR_RFORWARD:  begin x = VEC_POS; y = VEC_POS; end
      DIR_RBACKWARD: begin x = VEC_POS; y = VEC_NEG; end
      default:       known = 1'b0;
    endcase
  end

endmodule

// File: rtl/direction_encoder.sv
// Move-command encoder: timed (xDir, yDir) drive with abort and done/error pulses.
// Optional y-reversal dead-time is built only when DIRENC_DEADTIME_EN is defined.
module direction_encoder
  import direction_encoder_pkg::*;
#(
  parameter int DUR_W       = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_dir,
  input  logic [DUR_W-1:0] cmd_steps,
  input  logic             abort,
  output logic [1:0]       xDir,
  output logic [1:0]       yDir,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  state_t           state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [1:0]       x_d, y_d, last_y_q, last_y_d;
  logic             busy_d, done_d, err_d;
  logic [1:0]       vec_x, vec_y;
  logic             known, accept, degenerate;

`ifdef DIRENC_DEADTIME_EN
  localparam int DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]        px_q, px_d, py_q, py_d;
  logic              reversal;

  assign reversal = (DEAD_CYCLES != 0) && (last_y_q != VEC_ZERO) &&
                    (vec_y != VEC_ZERO) && (vec_y != last_y_q);
`endif

  dir_code_to_vec u_vec (
    .code  (cmd_dir),
    .x     (vec_x),
    .y     (vec_y),
    .known (known)
  );

  assign cmd_ready  = (state_q == ST_IDLE) && !abort;
  assign accept     = cmd_valid && cmd_ready;
  assign degenerate = (cmd_dir == DIR_NONE) || (cmd_steps == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = xDir;
    y_d      = yDir;
    last_y_d = last_y_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef DIRENC_DEADTIME_EN
    dcnt_d   = dcnt_q;
    px_d     = px_q;
    py_d     = py_q;
`endif
    case (state_q)
      ST_IDLE: begin
        x_d = VEC_ZERO;
        y_d = VEC_ZERO;
        if (accept) begin
          if (!known) begin
            err_d = 1'b1;
          end else if (degenerate) begin
            done_d = 1'b1;
          end else begin
            cnt_d = cmd_steps;
`ifdef DIRENC_DEADTIME_EN
            // Reversal parks the pair and leaves the step count loaded for DRIVE.
            if (reversal) begin
              state_d = ST_DEAD;
              dcnt_d  = DCNT_W'(DEAD_CYCLES);
              px_d    = vec_x;
              py_d    = vec_y;
            end else
`endif
            begin
              state_d  = ST_DRIVE;
              x_d      = vec_x;
              y_d      = vec_y;
              last_y_d = vec_y;
            end
          end
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = VEC_ZERO;
          y_d     = VEC_ZERO;
          cnt_d   = '0;
        end else if (cnt_q <= DUR_W'(1)) begin
          state_d = ST_IDLE;
          x_d     = VEC_ZERO;
          y_d     = VEC_ZERO;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
`ifdef DIRENC_DEADTIME_EN
      ST_DEAD: begin
        x_d = VEC_ZERO;
        y_d = VEC_ZERO;
        if (abort) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
          cnt_d   = '0;
        end else if (dcnt_q <= DCNT_W'(1)) begin
          state_d  = ST_DRIVE;
          dcnt_d   = '0;
          x_d      = px_q;
          y_d      = py_q;
          last_y_d = py_q;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        x_d     = VEC_ZERO;
        y_d     = VEC_ZERO;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      xDir     <= VEC_ZERO;
      yDir     <= VEC_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      last_y_q <= VEC_ZERO;
`ifdef DIRENC_DEADTIME_EN
      dcnt_q   <= '0;
      px_q     <= VEC_ZERO;
      py_q     <= VEC_ZERO;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xDir     <= x_d;
      yDir     <= y_d;
      busy     <= busy_d;
      done     <= done_d;
      cmd_err  <= err_d;
      last_y_q <= last_y_d;
`ifdef DIRENC_DEADTIME_EN
      dcnt_q   <= dcnt_d;
      px_q     <= px_d;
      py_q     <= py_d;
`endif
    end
  end

endmodule

// File: tb/tb_direction_encoder.sv
// Bench for direction_encoder: expected per-cycle output frames are queued at
// command issue and consumed by an independent monitor.
module tb_direction_encoder;
  import direction_encoder_pkg::*;

  localparam int DUR_W = 16;
  localparam int DEAD  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_dir;
  logic [DUR_W-1:0] cmd_steps;
  logic             abort;
  logic [1:0]       xDir, yDir;
  logic             busy, done, cmd_err;

  always #5 clk = ~clk;

  direction_encoder #(.DUR_W(DUR_W), .DEAD_CYCLES(DEAD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .xDir      (xDir),
    .yDir      (yDir),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       busy;
    logic       done;
    logic       err;
    logic       lb;
    logic       entry;
    logic [2:0] code;
  } frame_t;

  frame_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  logic   m_busy   = 1'b0;
  int     m_last_y = 0;

  function automatic logic [1:0] enc(input int v);
    return (v < 0) ? 2'b11 : (v > 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic int sgn(input logic [1:0] v);
    return (v == 2'b11) ? -1 : (v == 2'b01) ? 1 : 0;
  endfunction

  task automatic ref_pair(input logic [2:0] d, output int x, output int y);
    x = 0; y = 0;
    case (d)
      DIR_FORWARD:   begin x =  0; y =  1; end
      DIR_BACKWARD:  begin x =  0; y = -1; end
      DIR_LFORWARD:  begin x = -1; y =  1; end
      DIR_LBACKWARD: begin x = -1; y = -1; end
      DIR_RFORWARD:  begin x =  1; y =  1; end
      DIR_RBACKWARD: begin x =  1; y = -1; end
      default:       begin x =  0; y =  0; end
    endcase
  endtask

  function automatic logic [2:0] decode(input int x, input int y);
    if (y == 0) return (x == 0) ? DIR_NONE : DIR_INVALID;
    if (y > 0)  return (x < 0) ? DIR_LFORWARD  : (x > 0) ? DIR_RFORWARD  : DIR_FORWARD;
    return             (x < 0) ? DIR_LBACKWARD : (x > 0) ? DIR_RBACKWARD : DIR_BACKWARD;
  endfunction

  function automatic frame_t mkf(input int x, input int y, input logic b, input logic dn,
                                 input logic er, input logic lb, input logic en,
                                 input logic [2:0] code);
    frame_t f;
    f.x = enc(x); f.y = enc(y); f.busy = b; f.done = dn; f.err = er;
    f.lb = lb; f.entry = en; f.code = code;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  task automatic plan(input logic [2:0] d, input logic [DUR_W-1:0] s);
    int x, y;
    int dead = 0;
    if (d == DIR_INVALID) begin
      exp_q.push_back(mkf(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d));
    end else if (d == DIR_NONE || s == '0) begin
      exp_q.push_back(mkf(0, 0, 1'b0, 1'b1, 1'b0, d == DIR_NONE, 1'b0, DIR_NONE));
    end else begin
      ref_pair(d, x, y);
`ifdef DIRENC_DEADTIME_EN
      if (m_last_y != 0 && y != m_last_y) dead = DEAD;
`endif
      for (int i = 0; i < dead; i++)
        exp_q.push_back(mkf(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d));
      for (int i = 0; i < int'(s); i++)
        exp_q.push_back(mkf(x, y, 1'b1, 1'b0, 1'b0, 1'b1, i == 0, d));
      exp_q.push_back(mkf(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d));
    end
  endtask

  // Monitor: one expected frame per clock; an empty queue means an idle frame.
  initial begin
    frame_t f;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      if (exp_q.size() > 0) f = exp_q.pop_front();
      else f = mkf(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DIR_NONE);
      check("frame{x,y,busy,done,err}", 32'({xDir, yDir, busy, done, cmd_err}),
            32'({f.x, f.y, f.busy, f.done, f.err}));
      if (f.lb) check("loopback", 32'(decode(sgn(xDir), sgn(yDir))), 32'(f.code));
      m_busy = f.busy;
      if (f.entry) m_last_y = sgn(f.y);
    end
  end

  // Called just after a falling edge; returns at the next falling edge.
  task automatic drive(input logic v, input logic [2:0] d, input logic [DUR_W-1:0] s,
                       input logic a);
    cmd_valid = v; cmd_dir = d; cmd_steps = s; abort = a;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !a));
    if (a && m_busy) exp_q.delete();
    else if (v && !m_busy && !a) plan(d, s);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, DIR_NONE, '0, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      idle();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'({xDir, yDir, busy, done, cmd_err}), 32'd0);
    exp_q.delete();
    m_busy   = 1'b0;
    m_last_y = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = DIR_NONE; cmd_steps = '0; abort = 1'b0;
    #3;
    check("reset_outputs", 32'({xDir, yDir, busy, done, cmd_err}), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic forward drive
    drive(1'b1, DIR_FORWARD, 16'd3, 1'b0);
    wait_drain();
    idle(); idle();

    // Back-to-back y reversal
    drive(1'b1, DIR_RFORWARD, 16'd2, 1'b0);
    wait_drain();
    drive(1'b1, DIR_RBACKWARD, 16'd2, 1'b0);
    wait_drain();
    idle();

    // Abort during drive cycle 4
    drive(1'b1, DIR_LBACKWARD, 16'd10, 1'b0);
    idle(); idle(); idle();
    drive(1'b0, DIR_NONE, '0, 1'b1);
    idle();
    wait_drain();

    // Degenerate commands, back-to-back, plus abort blocking accept in IDLE
    drive(1'b1, DIR_INVALID, 16'd5, 1'b0);
    drive(1'b1, DIR_NONE, 16'd4, 1'b0);
    drive(1'b1, DIR_FORWARD, 16'd0, 1'b0);
    drive(1'b1, DIR_FORWARD, 16'd3, 1'b1);
    wait_drain();
    idle();

    // Reset in the middle of a drive, then a reversed short move
    drive(1'b1, DIR_FORWARD, 16'd8, 1'b0);
    idle(); idle();
    reset_mid();
    drive(1'b1, DIR_BACKWARD, 16'd1, 1'b0);
    wait_drain();

    // Loopback over every valid code
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 3'(c), 16'd2, 1'b0);
      wait_drain();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            DUR_W'($urandom_range(0, 5)), $urandom_range(0, 19) == 0);
    end
    wait_drain();
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
